// File: rtl/arb_mux_n.sv
// arb_mux_n: registered N-to-1 arbitrated select stage with valid/ready on
// every input channel and on the output.
//
// Requesters are granted either round-robin (search starts at ptr and
// wraps modulo N) or by fixed priority (lowest index wins). The winner is
// captured into a one-entry output register.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   flush      synchronous discard of the output register contents
//   req_valid  per-channel request valid            [N-1:0]
//   req_data   channel i occupies bits [i*W +: W]   [N*W-1:0]
//   req_ready  per-channel accept, one-hot or zero  [N-1:0]
//   out_valid  output register holds a transfer
//   out_data   registered winning data              [W-1:0]
//   out_sel    index of the channel behind out_data [SW-1:0]
//   out_ready  consumer accepts out_data
module arb_mux_n #(
  parameter int N         = 3,
  parameter int W         = 32,
  parameter int PRIO_MODE = 0,
  parameter int SW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_data,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_eff;
  logic [SW-1:0] ptr_nx;
  logic [N-1:0]  rot;
  logic          found;
  logic [SW:0]   off;
  logic [SW:0]   wsum;
  logic [SW-1:0] win;
  logic [N-1:0]  grant;
  logic          can_accept;
  logic          take;
  logic [W-1:0]  cap_data;

  assign out_valid = (state == FULL);

  // Rotate the request vector so the search always scans from bit 0, then
  // map the found offset back to an absolute channel index modulo N.
  always_comb begin
    ptr_eff = (PRIO_MODE != 0) ? '0 : ptr;
    rot     = N'({req_valid, req_valid} >> ptr_eff);
    found   = 1'b0;
    off     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = (SW+1)'(k);
      end
    end
    wsum = {1'b0, ptr_eff} + off;
    if (wsum >= (SW+1)'(N)) wsum = wsum - (SW+1)'(N);
    win   = wsum[SW-1:0];
    grant = found ? (N'(1) << win) : '0;
  end

  // rst is folded in so nothing is accepted while reset is held.
  assign can_accept = rst & ~flush & (~out_valid | out_ready);
  assign req_ready  = grant & {N{can_accept}};
  assign take       = found & can_accept;
  assign ptr_nx     = (win == SW'(N-1)) ? '0 : win + 1'b1;

  always_comb begin
    cap_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) cap_data = req_data[i*W +: W];
    end
  end

  always_comb begin
    state_nx = state;
    if (flush)          state_nx = EMPTY;
    else if (take)      state_nx = FULL;
    else if (out_ready) state_nx = EMPTY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else if (take) begin
      out_data <= cap_data;
      out_sel  <= win;
      if (PRIO_MODE == 0 && N > 1) ptr <= ptr_nx;
    end
  end

endmodule

// File: tb/tb_arb_mux_n.sv
// Testbench for arb_mux_n: a round-robin and a fixed-priority instance
// driven by the same inputs, checked against constant vector tables,
// hand-written reset sequences and a behavioural reference model.
module tb_arb_mux_n;
  localparam int N  = 3;
  localparam int W  = 32;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*W-1:0]  req_data = '0;

  logic [N-1:0]    rr_ready, fp_ready;
  logic            rr_valid, fp_valid;
  logic [W-1:0]    rr_data, fp_data;
  logic [SW-1:0]   rr_sel, fp_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arb_mux_n #(.N(N), .W(W), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid),
    .req_data(req_data), .req_ready(rr_ready), .out_valid(rr_valid),
    .out_data(rr_data), .out_sel(rr_sel), .out_ready(out_ready)
  );

  arb_mux_n #(.N(N), .W(W), .PRIO_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid),
    .req_data(req_data), .req_ready(fp_ready), .out_valid(fp_valid),
    .out_data(fp_data), .out_sel(fp_sel), .out_ready(out_ready)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: first valid channel scanning start, start+1, ... modulo N.
  function automatic int winner(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  typedef struct {
    logic [2:0]  v;
    logic [31:0] d1;
    logic        ordy;
    logic        fl;
    logic [2:0]  rr_rdy;
    logic [1:0]  rr_sel;
    logic [31:0] rr_dat;
    logic [2:0]  fp_rdy;
    logic [1:0]  fp_sel;
    logic [31:0] fp_dat;
    logic        ov;
  } vec_t;

  vec_t tbl[19];

  // model state
  bit          m_rv, m_fv;
  logic [31:0] m_rd, m_fd;
  int          m_rs, m_fs, m_ptr;

  initial begin
    // ch0=A, ch2=C always; ch1 = d1. One row per clock cycle.
    tbl[0]  = '{3'b111, 32'hB,        1'b1, 1'b0, 3'b001, 2'd0, 32'hA,        3'b001, 2'd0, 32'hA,        1'b1};
    tbl[1]  = '{3'b111, 32'hB,        1'b1, 1'b0, 3'b010, 2'd1, 32'hB,        3'b001, 2'd0, 32'hA,        1'b1};
    tbl[2]  = '{3'b111, 32'hB,        1'b1, 1'b0, 3'b100, 2'd2, 32'hC,        3'b001, 2'd0, 32'hA,        1'b1};
    tbl[3]  = '{3'b111, 32'hB,        1'b1, 1'b0, 3'b001, 2'd0, 32'hA,        3'b001, 2'd0, 32'hA,        1'b1};
    tbl[4]  = '{3'b111, 32'hB,        1'b1, 1'b0, 3'b010, 2'd1, 32'hB,        3'b001, 2'd0, 32'hA,        1'b1};
    tbl[5]  = '{3'b111, 32'hB,        1'b1, 1'b0, 3'b100, 2'd2, 32'hC,        3'b001, 2'd0, 32'hA,        1'b1};
    tbl[6]  = '{3'b010, 32'h12345678, 1'b1, 1'b0, 3'b010, 2'd1, 32'h12345678, 3'b010, 2'd1, 32'h12345678, 1'b1};
    tbl[7]  = '{3'b111, 32'hB,        1'b0, 1'b0, 3'b000, 2'd1, 32'h12345678, 3'b000, 2'd1, 32'h12345678, 1'b1};
    tbl[8]  = '{3'b111, 32'hB,        1'b0, 1'b0, 3'b000, 2'd1, 32'h12345678, 3'b000, 2'd1, 32'h12345678, 1'b1};
    tbl[9]  = '{3'b111, 32'hB,        1'b0, 1'b0, 3'b000, 2'd1, 32'h12345678, 3'b000, 2'd1, 32'h12345678, 1'b1};
    tbl[10] = '{3'b111, 32'hB,        1'b0, 1'b0, 3'b000, 2'd1, 32'h12345678, 3'b000, 2'd1, 32'h12345678, 1'b1};
    tbl[11] = '{3'b111, 32'hB,        1'b1, 1'b0, 3'b100, 2'd2, 32'hC,        3'b001, 2'd0, 32'hA,        1'b1};
    tbl[12] = '{3'b001, 32'hB,        1'b1, 1'b1, 3'b000, 2'd2, 32'hC,        3'b000, 2'd0, 32'hA,        1'b0};
    tbl[13] = '{3'b001, 32'hB,        1'b1, 1'b0, 3'b001, 2'd0, 32'hA,        3'b001, 2'd0, 32'hA,        1'b1};
    tbl[14] = '{3'b111, 32'hB,        1'b1, 1'b0, 3'b010, 2'd1, 32'hB,        3'b001, 2'd0, 32'hA,        1'b1};
    tbl[15] = '{3'b100, 32'hB,        1'b1, 1'b0, 3'b100, 2'd2, 32'hC,        3'b100, 2'd2, 32'hC,        1'b1};
    tbl[16] = '{3'b101, 32'hB,        1'b1, 1'b0, 3'b001, 2'd0, 32'hA,        3'b001, 2'd0, 32'hA,        1'b1};
    tbl[17] = '{3'b000, 32'hB,        1'b1, 1'b0, 3'b000, 2'd0, 32'hA,        3'b000, 2'd0, 32'hA,        1'b0};
    tbl[18] = '{3'b000, 32'hB,        0,    1'b0, 3'b000, 2'd0, 32'hA,        3'b000, 2'd0, 32'hA,        1'b0};

    // reset state, with requests present
    req_valid = 3'b111;
    req_data  = {32'hC, 32'hB, 32'hA};
    out_ready = 1'b1;
    #2;
    chk("reset rr_valid", 64'(rr_valid), 64'd0);
    chk("reset rr_data",  64'(rr_data),  64'd0);
    chk("reset rr_sel",   64'(rr_sel),   64'd0);
    chk("reset rr_ready", 64'(rr_ready), 64'd0);
    chk("reset fp_ready", 64'(fp_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int r = 0; r < 19; r++) begin
      req_valid = tbl[r].v;
      req_data  = {32'hC, tbl[r].d1, 32'hA};
      out_ready = tbl[r].ordy;
      flush     = tbl[r].fl;
      #1;
      chk($sformatf("row%0d rr_ready", r), 64'(rr_ready), 64'(tbl[r].rr_rdy));
      chk($sformatf("row%0d fp_ready", r), 64'(fp_ready), 64'(tbl[r].fp_rdy));
      @(posedge clk); #1;
      chk($sformatf("row%0d rr_valid", r), 64'(rr_valid), 64'(tbl[r].ov));
      chk($sformatf("row%0d rr_sel", r),   64'(rr_sel),   64'(tbl[r].rr_sel));
      chk($sformatf("row%0d rr_data", r),  64'(rr_data),  64'(tbl[r].rr_dat));
      chk($sformatf("row%0d fp_valid", r), 64'(fp_valid), 64'(tbl[r].ov));
      chk($sformatf("row%0d fp_sel", r),   64'(fp_sel),   64'(tbl[r].fp_sel));
      chk($sformatf("row%0d fp_data", r),  64'(fp_data),  64'(tbl[r].fp_dat));
    end

    // reset mid-stream: rr ptr is 1 here, capture DEADBEEF on ch0 (ptr stays 1)
    flush     = 1'b0;
    req_valid = 3'b001;
    req_data  = {32'hC, 32'hB, 32'hDEADBEEF};
    out_ready = 1'b0;
    #1;
    chk("mid rr_ready", 64'(rr_ready), 64'b001);
    @(posedge clk); #1;
    chk("mid rr_valid", 64'(rr_valid), 64'd1);
    chk("mid rr_data",  64'(rr_data),  64'hDEADBEEF);
    #2;
    rst = 1'b0;
    #1;
    chk("async rr_valid", 64'(rr_valid), 64'd0);
    chk("async rr_data",  64'(rr_data),  64'd0);
    chk("async rr_ready", 64'(rr_ready), 64'd0);
    chk("async fp_valid", 64'(fp_valid), 64'd0);
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = 3'b111;
    req_data  = {32'hC, 32'hB, 32'hA};
    out_ready = 1'b1;
    #1;
    chk("post rst rr_ready", 64'(rr_ready), 64'b001);
    @(posedge clk); #1;
    chk("post rst rr_sel",  64'(rr_sel),  64'd0);
    chk("post rst rr_data", 64'(rr_data), 64'hA);

    // randomized phase from a clean reset, against the reference model
    rst = 1'b0;
    #2;
    @(posedge clk); #1;
    rst  = 1'b1;
    m_rv = 0; m_fv = 0; m_rd = '0; m_fd = '0; m_rs = 0; m_fs = 0; m_ptr = 0;
    for (int c = 0; c < 3000; c++) begin
      bit can_r, can_f;
      int wr, wf;
      logic [N-1:0] er, ef;
      req_valid = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      can_r = (!m_rv || out_ready) && !flush;
      can_f = (!m_fv || out_ready) && !flush;
      wr = winner(req_valid, m_ptr);
      wf = winner(req_valid, 0);
      er = (can_r && wr >= 0) ? N'(1 << wr) : '0;
      ef = (can_f && wf >= 0) ? N'(1 << wf) : '0;
      #1;
      chk($sformatf("rand%0d rr_ready", c), 64'(rr_ready), 64'(er));
      chk($sformatf("rand%0d fp_ready", c), 64'(fp_ready), 64'(ef));
      if (flush) m_rv = 0;
      else if (er != 0) begin
        m_rv = 1; m_rd = req_data[wr*W +: W]; m_rs = wr; m_ptr = (wr + 1) % N;
      end else if (out_ready) m_rv = 0;
      if (flush) m_fv = 0;
      else if (ef != 0) begin
        m_fv = 1; m_fd = req_data[wf*W +: W]; m_fs = wf;
      end else if (out_ready) m_fv = 0;
      @(posedge clk); #1;
      chk($sformatf("rand%0d rr_out", c), {rr_valid, 29'd0, rr_sel, rr_data},
          {m_rv, 29'd0, 2'(m_rs), m_rd});
      chk($sformatf("rand%0d fp_out", c), {fp_valid, 29'd0, fp_sel, fp_data},
          {m_fv, 29'd0, 2'(m_fs), m_fd});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
